// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and address-offset helpers for the cache-line / burst adaptor.
package cacheline_adaptor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } adaptor_state_t;

  // Number of byte-offset address bits covered by an item of width_bits.
  function automatic int byte_off(input int width_bits);
    return $clog2(width_bits / 8);
  endfunction

  localparam int DEF_OFF  = byte_off(256);
  localparam int DEF_BOFF = byte_off(64);

endpackage

// File: rtl/beat_counter.sv
// Beat index (wraps modulo 2**W) plus a count of accepted beats.
module beat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_start,
  input  logic         i_inc,
  output logic [W-1:0] o_idx,
  output logic [W-1:0] o_idx_next,
  output logic [W:0]   o_count
);

  logic [W-1:0] r_idx;
  logic [W:0]   r_count;

  assign o_idx      = r_idx;
  assign o_idx_next = r_idx + W'(1);
  assign o_count    = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_idx   <= i_start;
      r_count <= '0;
    end else if (i_inc) begin
      r_idx   <= o_idx_next;
      r_count <= r_count + (W+1)'(1);
    end
  end

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Bridges one-line LLC transactions to BEATS-long bursts on the memory side,
// with write priority and optional critical-word-first read fills.
module cacheline_burst_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int LINE_W     = 256,
  parameter int BURST_W    = 64,
  parameter int ADDR_W     = 32,
  parameter int CRIT_FIRST = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CW    = $clog2(BEATS);
  localparam int OFF   = byte_off(LINE_W);
  localparam int BOFF  = byte_off(BURST_W);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] BEAT_MASK = ~((ADDR_W'(1) << BOFF) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] RD_MASK   = (CRIT_FIRST != 0) ? BEAT_MASK : LINE_MASK;
  localparam logic [CW:0]       CNT_LAST  = (CW+1)'(BEATS - 1);

  if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0 || BEATS * BURST_W != LINE_W) begin : g_bad_cfg
    $error("cacheline_burst_adaptor: LINE_W/BURST_W must be a power of two >= 2");
  end

  adaptor_state_t r_state;
  logic [BEATS-1:0][BURST_W-1:0] r_wline;
  logic [BEATS-1:0][BURST_W-1:0] r_fill;

  logic [BEATS-1:0][BURST_W-1:0] w_line_in;
  logic          w_accept_wr;
  logic          w_accept_rd;
  logic          w_beat;
  logic          w_last;
  logic [CW-1:0] w_start;
  logic [CW-1:0] w_idx;
  logic [CW-1:0] w_idx_next;
  logic [CW:0]   w_count;

  assign w_line_in   = line_i;
  assign line_o      = r_fill;
  assign w_accept_wr = (r_state == IDLE) && write_i;
  assign w_accept_rd = (r_state == IDLE) && !write_i && read_i;
  assign w_beat      = resp_i && ((r_state == READ) || (r_state == WRITE));
  assign w_last      = (w_count == CNT_LAST);
  assign w_start     = ((CRIT_FIRST != 0) && w_accept_rd) ? address_i[OFF-1:BOFF] : '0;

  beat_counter #(.W(CW)) u_beat_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept_wr || w_accept_rd),
    .i_start    (w_start),
    .i_inc      (w_beat),
    .o_idx      (w_idx),
    .o_idx_next (w_idx_next),
    .o_count    (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
      burst_o   <= '0;
      address_o <= '0;
      r_fill    <= '0;
      r_wline   <= '0;
    end else begin
      resp_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (write_i) begin
            r_state   <= WRITE;
            write_o   <= 1'b1;
            address_o <= address_i & LINE_MASK;
            r_wline   <= w_line_in;
            burst_o   <= w_line_in[0];
          end else if (read_i) begin
            r_state   <= READ;
            read_o    <= 1'b1;
            address_o <= address_i & RD_MASK;
          end
        end
        READ: begin
          if (resp_i) begin
            r_fill[w_idx] <= burst_i;
            if (w_last) begin
              read_o  <= 1'b0;
              resp_o  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        WRITE: begin
          // Next beat is presented the cycle after the current one is accepted.
          if (resp_i) begin
            burst_o <= r_wline[w_idx_next];
            if (w_last) begin
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed checks of the adaptor in default, critical-word-first and wide-line configurations.
module tb_cacheline_burst_adaptor;

  logic clk;
  logic reset;

  // Group A: default and CRIT_FIRST instances share all inputs.
  logic [255:0] a_line;
  logic [31:0]  a_addr;
  logic         a_rd, a_wr, a_resp;
  logic [63:0]  a_burst;
  logic [255:0] o0_line, o1_line;
  logic [63:0]  o0_burst, o1_burst;
  logic [31:0]  o0_addr, o1_addr;
  logic         o0_rd, o0_wr, o0_resp, o1_rd, o1_wr, o1_resp;

  // Group B: 512-bit lines.
  logic [511:0] b_line;
  logic [31:0]  b_addr;
  logic         b2_rd, b2_wr, b2_resp, b3_rd, b3_wr, b3_resp;
  logic [127:0] b2_burst;
  logic [63:0]  b3_burst;
  logic [511:0] o2_line, o3_line;
  logic [127:0] o2_burst;
  logic [63:0]  o3_burst;
  logic [31:0]  o2_addr, o3_addr;
  logic         o2_rd, o2_wr, o2_resp, o3_rd, o3_wr, o3_resp;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0]  va [4] = '{64'hA0A0_0000_0000_00A0, 64'hA1A1_0000_0000_00A1,
                           64'hA2A2_0000_0000_00A2, 64'hA3A3_0000_0000_00A3};
  logic [63:0]  vb [4] = '{64'hB0B0_1111_0000_00B0, 64'hB1B1_1111_0000_00B1,
                           64'hB2B2_1111_0000_00B2, 64'hB3B3_1111_0000_00B3};
  logic [63:0]  vw [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                           64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
  logic [63:0]  vc [4] = '{64'hC0C0_2222_0000_00C0, 64'hC1C1_2222_0000_00C1,
                           64'hC2C2_2222_0000_00C2, 64'hC3C3_2222_0000_00C3};
  logic [63:0]  vd [2] = '{64'hD0D0_3333_0000_00D0, 64'hD1D1_3333_0000_00D1};
  logic [63:0]  ve [4] = '{64'hE0E0_4444_0000_00E0, 64'hE1E1_4444_0000_00E1,
                           64'hE2E2_4444_0000_00E2, 64'hE3E3_4444_0000_00E3};
  logic [255:0] l2 = {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
                      64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};
  logic [511:0] cap;

  cacheline_burst_adaptor u0 (
    .clk(clk), .reset(reset), .line_i(a_line), .line_o(o0_line), .address_i(a_addr),
    .read_i(a_rd), .write_i(a_wr), .resp_o(o0_resp), .burst_i(a_burst), .burst_o(o0_burst),
    .address_o(o0_addr), .read_o(o0_rd), .write_o(o0_wr), .resp_i(a_resp));

  cacheline_burst_adaptor #(.CRIT_FIRST(1)) u1 (
    .clk(clk), .reset(reset), .line_i(a_line), .line_o(o1_line), .address_i(a_addr),
    .read_i(a_rd), .write_i(a_wr), .resp_o(o1_resp), .burst_i(a_burst), .burst_o(o1_burst),
    .address_o(o1_addr), .read_o(o1_rd), .write_o(o1_wr), .resp_i(a_resp));

  cacheline_burst_adaptor #(.LINE_W(512), .BURST_W(128)) u2 (
    .clk(clk), .reset(reset), .line_i(b_line), .line_o(o2_line), .address_i(b_addr),
    .read_i(b2_rd), .write_i(b2_wr), .resp_o(o2_resp), .burst_i(b2_burst), .burst_o(o2_burst),
    .address_o(o2_addr), .read_o(o2_rd), .write_o(o2_wr), .resp_i(b2_resp));

  cacheline_burst_adaptor #(.LINE_W(512), .BURST_W(64)) u3 (
    .clk(clk), .reset(reset), .line_i(b_line), .line_o(o3_line), .address_i(b_addr),
    .read_i(b3_rd), .write_i(b3_wr), .resp_o(o3_resp), .burst_i(b3_burst), .burst_o(o3_burst),
    .address_o(o3_addr), .read_o(o3_rd), .write_o(o3_wr), .resp_i(b3_resp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_line = '0; a_addr = '0; a_rd = 0; a_wr = 0; a_resp = 0; a_burst = '0;
    b_line = '0; b_addr = '0; b2_rd = 0; b2_wr = 0; b2_resp = 0; b2_burst = '0;
    b3_rd = 0; b3_wr = 0; b3_resp = 0; b3_burst = '0;
    step; step;
    check("rst_rd", o0_rd, 0);
    check("rst_wr", o0_wr, 0);
    check("rst_resp", o0_resp, 0);
    check("rst_addr", o0_addr, 0);
    check("rst_line", o0_line, 0);
    check("rst_burst", o0_burst, 0);
    reset = 1'b0;

    // Default read at 0x1234, beats on consecutive cycles.
    a_addr = 32'h0000_1234; a_rd = 1;
    step;
    check("rd_addr", o0_addr, 32'h0000_1220);
    check("rd_rdo", o0_rd, 1);
    check("rd_crit_addr", o1_addr, 32'h0000_1230);
    a_addr = 32'hDEAD_BEEF;
    a_resp = 1;
    for (int k = 0; k < 4; k++) begin
      a_burst = va[k];
      step;
      if (k < 3) begin
        check("rd_noresp", o0_resp, 0);
        check("rd_hold", o0_rd, 1);
      end
    end
    check("rd_resp", o0_resp, 1);
    check("rd_rdo_low", o0_rd, 0);
    check("rd_line", o0_line, {va[3], va[2], va[1], va[0]});
    check("rd_crit_resp", o1_resp, 1);
    check("rd_crit_line", o1_line, {va[1], va[0], va[3], va[2]});
    a_rd = 0; a_resp = 0;
    step;
    check("rd_resp_end", o0_resp, 0);
    check("rd_addr_hold", o0_addr, 32'h0000_1220);

    // Write with two idle cycles between accepted beats.
    a_line = {vw[3], vw[2], vw[1], vw[0]}; a_addr = 32'h0000_2044; a_wr = 1;
    step;
    check("wr_wro", o0_wr, 1);
    check("wr_addr", o0_addr, 32'h0000_2040);
    check("wr_crit_addr", o1_addr, 32'h0000_2040);
    a_line = '1; a_addr = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      repeat (2) begin
        step;
        check("wr_gap_wro", o0_wr, 1);
        check("wr_gap_rdo", o0_rd, 0);
        check("wr_gap_burst", o0_burst, vw[k]);
        check("wr_crit_burst", o1_burst, vw[k]);
        check("wr_gap_resp", o0_resp, 0);
      end
      a_resp = 1;
      step;
      a_resp = 0;
    end
    check("wr_resp", o0_resp, 1);
    check("wr_wro_low", o0_wr, 0);
    check("wr_crit_wro", o1_wr, 0);
    check("wr_line_kept", o0_line, {va[3], va[2], va[1], va[0]});
    a_wr = 0;
    step;
    check("wr_resp_end", o0_resp, 0);

    // Critical-word-first read at 0x1250 (beat 2).
    a_addr = 32'h0000_1250; a_rd = 1;
    step;
    check("cf_addr", o1_addr, 32'h0000_1250);
    check("cf_rdo", o1_rd, 1);
    check("cf_def_addr", o0_addr, 32'h0000_1240);
    a_resp = 1;
    for (int k = 0; k < 4; k++) begin
      a_burst = vb[k];
      step;
    end
    check("cf_resp", o1_resp, 1);
    check("cf_line", o1_line, {vb[1], vb[0], vb[3], vb[2]});
    check("cf_def_line", o0_line, {vb[3], vb[2], vb[1], vb[0]});
    a_rd = 0; a_resp = 0;
    step;

    // Read and write together: write first, read follows after IDLE.
    a_line = l2; a_addr = 32'h0000_3000; a_rd = 1; a_wr = 1; a_resp = 1;
    step;
    check("both_wr_first", o0_wr, 1);
    check("both_rd_wait", o0_rd, 0);
    repeat (3) step;
    check("both_wr_noresp", o0_resp, 0);
    step;
    check("both_wr_resp", o0_resp, 1);
    check("both_wr_low", o0_wr, 0);
    a_wr = 0;
    step;
    check("both_done_resp", o0_resp, 0);
    check("both_done_rd", o0_rd, 0);
    step;
    check("both_rd_start", o0_rd, 1);
    for (int k = 0; k < 4; k++) begin
      a_burst = vc[k];
      step;
    end
    check("both_rd_resp", o0_resp, 1);
    check("both_rd_line", o0_line, {vc[3], vc[2], vc[1], vc[0]});
    a_rd = 0; a_resp = 0;
    step;

    // Reset after two read beats, then a fresh read.
    a_addr = 32'h0000_5678; a_rd = 1;
    step;
    a_resp = 1;
    for (int k = 0; k < 2; k++) begin
      a_burst = vd[k];
      step;
    end
    #1 reset = 1'b1;
    #1;
    check("ar_rd", o0_rd, 0);
    check("ar_wr", o0_wr, 0);
    check("ar_addr", o0_addr, 0);
    check("ar_line", o0_line, 0);
    check("ar_burst", o0_burst, 0);
    check("ar_resp", o0_resp, 0);
    a_resp = 0;
    step; step;
    check("ar_noresp", o0_resp, 0);
    reset = 1'b0;
    step;
    check("ar2_rdo", o0_rd, 1);
    check("ar2_addr", o0_addr, 32'h0000_5660);
    a_resp = 1;
    for (int k = 0; k < 4; k++) begin
      a_burst = ve[k];
      step;
    end
    check("ar2_resp", o0_resp, 1);
    check("ar2_line", o0_line, {ve[3], ve[2], ve[1], ve[0]});
    a_rd = 0; a_resp = 0;
    step;

    // 512/128 round trip.
    for (int i = 0; i < 16; i++) b_line[i*32 +: 32] = 32'hC0DE_0000 + i;
    b_addr = 32'h0000_3FC4;
    b2_wr = 1; b2_resp = 1;
    step;
    check("w128_addr", o2_addr, 32'h0000_3FC0);
    check("w128_wro", o2_wr, 1);
    cap = '0;
    for (int k = 0; k < 4; k++) begin
      cap[k*128 +: 128] = o2_burst;
      step;
    end
    check("w128_resp", o2_resp, 1);
    check("w128_line", cap, b_line);
    b2_wr = 0; b2_resp = 0;
    step;
    b2_rd = 1;
    step;
    check("r128_rdo", o2_rd, 1);
    b2_resp = 1;
    for (int k = 0; k < 4; k++) begin
      b2_burst = cap[k*128 +: 128];
      step;
    end
    check("r128_resp", o2_resp, 1);
    check("r128_line", o2_line, b_line);
    b2_rd = 0; b2_resp = 0;
    step;

    // 512/64 round trip.
    b3_wr = 1; b3_resp = 1;
    step;
    check("w64_addr", o3_addr, 32'h0000_3FC0);
    check("w64_wro", o3_wr, 1);
    cap = '0;
    for (int k = 0; k < 8; k++) begin
      cap[k*64 +: 64] = o3_burst;
      step;
      if (k < 7) check("w64_noresp", o3_resp, 0);
    end
    check("w64_resp", o3_resp, 1);
    check("w64_line", cap, b_line);
    b3_wr = 0; b3_resp = 0;
    step;
    b3_rd = 1;
    step;
    check("r64_rdo", o3_rd, 1);
    b3_resp = 1;
    for (int k = 0; k < 8; k++) begin
      b3_burst = cap[k*64 +: 64];
      step;
    end
    check("r64_resp", o3_resp, 1);
    check("r64_line", o3_line, b_line);
    b3_rd = 0; b3_resp = 0;
    step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
